sobel_edge_filter: RTL and testbench
====================================

Name: sobel_edge_filter

Overview:
- Streaming 3x3 Sobel stage directly downstream of the greyscale/demosaic stage in the DE1-SoC camera pipeline.
- Consumes one 12-bit greyscale pixel per iDVAL strobe and buffers the two previous rows internally.
- Produces an edge magnitude, horizontal or vertical kernel, on oRed/oGreen/oBlue for the SDRAM write path.
- When edge detection is disabled, it passes the grey pixel through with identical latency.

Parameters:
- IMG_WIDTH, 640, accepted pixels per row; line buffer depth.
- DATA_W, 12, pixel width.

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  asynchronous active-low reset
- iSOF  in  1  one-cycle start-of-frame pulse
- iDATA  in  DATA_W  greyscale pixel
- iDVAL  in  1  iDATA valid; one pixel accepted per high cycle
- iIsEdgeDetect  in  1  1 = Sobel output, 0 = grey passthrough
- iIsHorizontalEdge  in  1  1 = Gy kernel (horizontal edges), 0 = Gx kernel
- oRed  out  DATA_W  result
- oGreen  out  DATA_W  result (equal to oRed)
- oBlue  out  DATA_W  result (equal to oRed)
- oDVAL  out  1  result valid

Behaviour:
- Reset (iRST low, asynchronous):
  - oRed/oGreen/oBlue = 0, oDVAL = 0.
  - Column and row counters = 0, window registers = 0, pipeline valids = 0, latched modes = 0.
  - Line buffer contents are don't-care.
- Counters, advanced only on accepted pixels (iDVAL=1):
  - col counts 0..IMG_WIDTH-1; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - row saturates at 2047.
- iSOF:
  - Clears col and row to 0.
  - Latches iIsEdgeDetect and iIsHorizontalEdge into mode registers. Mode is constant for the whole frame; mid-frame toggles take effect at the next iSOF.
  - iSOF and iDVAL in the same cycle: the counters clear and that pixel is accepted as (0,0).
  - iSOF does not flush the pipeline. Pixels already in flight complete with their original flags.
- Line buffers:
  - Two cascaded delay lines of IMG_WIDTH entries, advanced only on accepted pixels.
  - They provide the pixels at (row-1, col) and (row-2, col).
  - Contents are not cleared on iSOF; border masking hides stale data.
- Window:
  - 3x3 registers p[r][c], r/c = 0..2, with row 0 the oldest and column 2 the newest.
  - The window shifts one column per accepted pixel. Its centre p11 is the pixel at (row-1, col-1) of the accepted pixel.
- Arithmetic:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - Partial sums are unsigned 14-bit; the difference is signed 15-bit.
  - Magnitude is |G|, saturated to 4095 (all ones).
- Border rule: if the accepted pixel's row < 2 or col < 2, the Sobel result is forced to 0. Passthrough mode is not masked.
- Output select:
  - Latched edge mode = 1: saturated |Gy| when the latched horizontal flag = 1, otherwise saturated |Gx|.
  - Latched edge mode = 0: p11.
- Pipeline (advances every clock regardless of iDVAL):
  - Stage 1: window/line-buffer update on acceptance.
  - Stage 2: register the partial sums and flags.
  - Stage 3: register abs/clamp/select into the outputs.
- Latency and valid:
  - oDVAL is high exactly 3 cycles after each iDVAL high cycle, and is high for one cycle per accepted pixel.
  - Back-to-back iDVAL gives back-to-back oDVAL.
  - iDVAL gaps are reproduced with the same spacing.
  - Output image is spatially offset by (-1,-1).
- Output hold: when oDVAL = 0 the outputs hold their last value.
- Reset mid-frame: the pipeline is cleared and no pending oDVAL is emitted. The next accepted pixel is treated as (0,0) with mode 0 until the next iSOF.

Test Plan:
- Reset release, iSOF with iIsEdgeDetect=0, iDATA=0x123 streamed -> each oDVAL 3 clocks after its iDVAL; outputs are p11 values, all = 0x123 once window filled; oRed=oGreen=oBlue.
- Edge mode Gx, uniform frame iDATA=2000 -> every output 0; rows 0-1 and cols 0-1 are 0 by border rule.
- Edge mode Gx, column step (cols<320 = 0, >=320 = 1000) -> 4000 at the columns adjacent to the step, 0 elsewhere. With 2000 instead of 1000 -> saturates to 4095.
- Edge mode Gy, row step (rows<100 = 0, >=100 = 500) -> 2000 on the rows adjacent to the step, 0 elsewhere; the same pattern in Gx mode -> 0.
- iDVAL asserted every other cycle with random gaps -> oDVAL reproduces the pattern delayed 3 clocks. Toggling iIsHorizontalEdge mid-frame has no effect until the next iSOF.
- iRST pulsed low mid-row with 3 pixels in flight -> outputs 0 and oDVAL 0 immediately, with no stale oDVAL after release. iSOF+iDVAL in the same cycle -> that pixel is taken as (0,0).

Source files
------------

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel edge stage for the camera pipeline.
// Takes one greyscale pixel per iDVAL, keeps the two previous rows in line
// buffers and emits |Gx| or |Gy| (saturated), or the window centre pixel
// in passthrough mode. The output trails the input by three clocks and is
// spatially offset by (-1,-1).
module sobel_edge_filter #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 12
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iIsEdgeDetect,
    input  logic              iIsHorizontalEdge,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL
);

    localparam int COL_W = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 2;
    localparam int ROW_W = 11;
    localparam int SUM_W = DATA_W + 2;
    localparam int DIF_W = DATA_W + 3;

    // ------------------------------------------------------------------
    // Frame position and per-frame mode
    // ------------------------------------------------------------------
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_mode_edge;
    logic             r_mode_horiz;
    logic             r_lb2_we;
    logic             r_rd_vld;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_edge;
    logic             w_horiz;
    logic             w_border;

    // A pixel arriving together with iSOF is position (0,0) of the new frame
    // and already uses the new frame's mode.
    assign w_col    = iSOF ? '0 : r_col;
    assign w_row    = iSOF ? '0 : r_row;
    assign w_edge   = iSOF ? iIsEdgeDetect : r_mode_edge;
    assign w_horiz  = iSOF ? iIsHorizontalEdge : r_mode_horiz;
    assign w_border = (w_row < ROW_W'(2)) || (w_col < COL_W'(2));

    // Column/row counters, mode latch and line-buffer control flags
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col        <= '0;
            r_row        <= '0;
            r_mode_edge  <= 1'b0;
            r_mode_horiz <= 1'b0;
            r_lb2_we     <= 1'b0;
            r_rd_vld     <= 1'b0;
        end else begin
            if (iSOF) begin
                r_mode_edge  <= iIsEdgeDetect;
                r_mode_horiz <= iIsHorizontalEdge;
            end
            if (iDVAL) begin
                if (w_col == COL_W'(IMG_WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= (w_row == '1) ? w_row : w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(1);
                    r_row <= w_row;
                end
            end else if (iSOF) begin
                r_col <= '0;
                r_row <= '0;
            end
            r_lb2_we <= iDVAL;
            if (iDVAL) begin
                r_rd_vld <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1[col] holds row-1, lb2[col] holds row-2.
    // Both have registered reads; lb2 is refilled one cycle after each
    // accepted pixel from the value just read out of lb1 at the same column.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_lb1 [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] r_lb2 [0:IMG_WIDTH-1];
    logic [DATA_W-1:0] r_lb1_q;
    logic [DATA_W-1:0] r_lb2_q;
    logic [COL_W-1:0]  r_lb2_waddr;

    // Read-first line buffer access on accepted pixels, deferred lb2 write
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            r_lb1[w_col] <= iDATA;
            r_lb1_q      <= r_lb1[w_col];
            r_lb2_q      <= r_lb2[w_col];
            r_lb2_waddr  <= w_col;
        end
        if (r_lb2_we) begin
            r_lb2[r_lb2_waddr] <= r_lb1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window. Column 2 is the newest column: rows 0/1 come
    // straight from the line-buffer read registers (forced to zero until
    // the first read after reset), row 2 is the latest input pixel.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_p22;
    logic              r_s1_vld;
    logic              r_s1_border;
    logic              r_s1_edge;
    logic              r_s1_horiz;
    logic [DATA_W-1:0] w_col2 [0:2];

    assign w_col2[0] = r_rd_vld ? r_lb2_q : '0;
    assign w_col2[1] = r_rd_vld ? r_lb1_q : '0;
    assign w_col2[2] = r_p22;

    // Newest pixel and the flags that travel with it
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_p22       <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_edge   <= 1'b0;
            r_s1_horiz  <= 1'b0;
        end else begin
            r_s1_vld <= iDVAL;
            if (iDVAL) begin
                r_p22       <= iDATA;
                r_s1_border <= w_border;
                r_s1_edge   <= w_edge;
                r_s1_horiz  <= w_horiz;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win_row
            logic [DATA_W-1:0] r_c0;
            logic [DATA_W-1:0] r_c1;
            // Shift this window row left by one column per accepted pixel
            always_ff @(posedge iCLK or negedge iRST) begin
                if (!iRST) begin
                    r_c0 <= '0;
                    r_c1 <= '0;
                end else if (iDVAL) begin
                    r_c0 <= r_c1;
                    r_c1 <= w_col2[gi];
                end
            end
        end
    endgenerate

    logic [DATA_W-1:0] w_p00, w_p01, w_p02;
    logic [DATA_W-1:0] w_p10, w_p11, w_p12;
    logic [DATA_W-1:0] w_p20, w_p21, w_p22;

    assign w_p00 = g_win_row[0].r_c0;
    assign w_p01 = g_win_row[0].r_c1;
    assign w_p02 = w_col2[0];
    assign w_p10 = g_win_row[1].r_c0;
    assign w_p11 = g_win_row[1].r_c1;
    assign w_p12 = w_col2[1];
    assign w_p20 = g_win_row[2].r_c0;
    assign w_p21 = g_win_row[2].r_c1;
    assign w_p22 = w_col2[2];

    // ------------------------------------------------------------------
    // Stage 2: positive/negative partial sums of the selected kernel
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [SUM_W-1:0] w_pos, w_neg;

    assign w_gx_pos = SUM_W'(w_p02) + SUM_W'({w_p12, 1'b0}) + SUM_W'(w_p22);
    assign w_gx_neg = SUM_W'(w_p00) + SUM_W'({w_p10, 1'b0}) + SUM_W'(w_p20);
    assign w_gy_pos = SUM_W'(w_p20) + SUM_W'({w_p21, 1'b0}) + SUM_W'(w_p22);
    assign w_gy_neg = SUM_W'(w_p00) + SUM_W'({w_p01, 1'b0}) + SUM_W'(w_p02);
    assign w_pos    = r_s1_horiz ? w_gy_pos : w_gx_pos;
    assign w_neg    = r_s1_horiz ? w_gy_neg : w_gx_neg;

    logic [SUM_W-1:0]  r_s2_pos;
    logic [SUM_W-1:0]  r_s2_neg;
    logic [DATA_W-1:0] r_s2_p11;
    logic              r_s2_vld;
    logic              r_s2_border;
    logic              r_s2_edge;

    // Register partial sums, centre pixel and flags every clock
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_s2_pos    <= '0;
            r_s2_neg    <= '0;
            r_s2_p11    <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_border <= 1'b0;
            r_s2_edge   <= 1'b0;
        end else begin
            r_s2_pos    <= w_pos;
            r_s2_neg    <= w_neg;
            r_s2_p11    <= w_p11;
            r_s2_vld    <= r_s1_vld;
            r_s2_border <= r_s1_border;
            r_s2_edge   <= r_s1_edge;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: |pos - neg|, clamp to full scale, border mask, mode select
    // ------------------------------------------------------------------
    logic [DIF_W-1:0]  w_diff;
    logic [DIF_W-1:0]  w_abs;
    logic [DATA_W-1:0] w_mag;
    logic [DATA_W-1:0] w_result;

    assign w_diff   = {1'b0, r_s2_pos} - {1'b0, r_s2_neg};
    assign w_abs    = w_diff[DIF_W-1] ? (~w_diff + DIF_W'(1)) : w_diff;
    assign w_mag    = (|w_abs[DIF_W-1:DATA_W]) ? '1 : w_abs[DATA_W-1:0];
    assign w_result = r_s2_edge ? (r_s2_border ? '0 : w_mag) : r_s2_p11;

    logic [DATA_W-1:0] r_out;
    logic              r_dval;

    // Output register; holds its value between valid results
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_out  <= '0;
            r_dval <= 1'b0;
        end else begin
            r_dval <= r_s2_vld;
            if (r_s2_vld) begin
                r_out <= w_result;
            end
        end
    end

    assign oRed   = r_out;
    assign oGreen = r_out;
    assign oBlue  = r_out;
    assign oDVAL  = r_dval;

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter using a narrow image width.
// Expected results are computed from the driven image when each pixel is
// sent and checked when the matching oDVAL appears three clocks later.
module tb_sobel_edge_filter;

    localparam int W    = 16;
    localparam int DW   = 12;
    localparam int MAXR = 16;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSOF = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic          iIsEdgeDetect = 1'b0;
    logic          iIsHorizontalEdge = 1'b0;
    logic [DW-1:0] oRed, oGreen, oBlue;
    logic          oDVAL;

    always #5 iCLK = ~iCLK;

    sobel_edge_filter #(
        .IMG_WIDTH(W),
        .DATA_W(DW)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iSOF(iSOF),
        .iDATA(iDATA),
        .iDVAL(iDVAL),
        .iIsEdgeDetect(iIsEdgeDetect),
        .iIsHorizontalEdge(iIsHorizontalEdge),
        .oRed(oRed),
        .oGreen(oGreen),
        .oBlue(oBlue),
        .oDVAL(oDVAL)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] val;
        bit            dc;
    } exp_t;

    exp_t          sb_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] last_out = '0;
    int            m_row = 0;
    int            m_col = 0;
    bit            m_edge = 1'b0;
    bit            m_horiz = 1'b0;
    logic [DW-1:0] img [0:MAXR-1][0:W-1];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge iCLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int p, input int r, input int c);
        case (p)
            0:       return 12'h123;
            1:       return 12'd2000;
            2:       return (c < W/2) ? 12'd0 : 12'd1000;
            3:       return (c < W/2) ? 12'd0 : 12'd2000;
            4:       return (r < 4) ? 12'd0 : 12'd500;
            default: return DW'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic int sobel(input int r, input int c, input bit h);
        int a [3][3];
        int pos, neg, g;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = int'(img[r-2+i][c-2+j]);
        if (h) begin
            pos = a[2][0] + 2*a[2][1] + a[2][2];
            neg = a[0][0] + 2*a[0][1] + a[0][2];
        end else begin
            pos = a[0][2] + 2*a[1][2] + a[2][2];
            neg = a[0][0] + 2*a[1][0] + a[2][0];
        end
        g = pos - neg;
        if (g < 0) g = -g;
        if (g > 4095) g = 4095;
        return g;
    endfunction

    // Output monitor: every clock either the scheduled result or an idle hold
    always @(negedge iCLK) begin
        if (!iRST) begin
            check_val("rst_dval", oDVAL, 0);
            check_val("rst_out", oRed, 0);
        end else if (sb_q.size() > 0 && sb_q[0].cyc + 3 == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("dval", oDVAL, 1);
            if (!e.dc) begin
                check_val("red", oRed, e.val);
                check_val("green", oGreen, e.val);
                check_val("blue", oBlue, e.val);
            end
            last_out = oRed;
        end else begin
            check_val("idle_dval", oDVAL, 0);
            check_val("hold", oRed, last_out);
        end
    end

    // Send one pixel for one clock and queue its expected result
    task automatic drive(input logic [DW-1:0] d, input bit sof, input bit e, input bit h);
        exp_t x;
        int r, c;
        iSOF = sof;
        iDVAL = 1'b1;
        iDATA = d;
        iIsEdgeDetect = e;
        iIsHorizontalEdge = h;
        if (sof) begin
            m_row = 0;
            m_col = 0;
            m_edge = e;
            m_horiz = h;
        end
        r = m_row;
        c = m_col;
        if (r < MAXR) img[r][c] = d;
        x.cyc = cyc;
        x.dc = 1'b0;
        x.val = '0;
        if (!m_edge) begin
            if (r >= 1 && c >= 1 && r <= MAXR) x.val = img[r-1][c-1];
            else x.dc = 1'b1;
        end else if (r < 2 || c < 2) begin
            x.val = '0;
        end else begin
            x.val = DW'(sobel(r, c, m_horiz));
        end
        sb_q.push_back(x);
        if (m_col == W - 1) begin
            m_col = 0;
            if (m_row < 2047) m_row++;
        end else begin
            m_col++;
        end
        @(posedge iCLK);
        #1;
        iSOF = 1'b0;
        iDVAL = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // Standalone start-of-frame pulse with no pixel
    task automatic sof_only(input bit e, input bit h);
        iSOF = 1'b1;
        iIsEdgeDetect = e;
        iIsHorizontalEdge = h;
        m_row = 0;
        m_col = 0;
        m_edge = e;
        m_horiz = h;
        idle(1);
        iSOF = 1'b0;
    endtask

    task automatic run_frame(input string name, input int p, input bit e, input bit h,
                             input int rows, input bit gaps, input bit toggle, input bit use_sof);
        int err0;
        err0 = n_err;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                bit hin;
                hin = (toggle && r >= rows/2) ? ~h : h;
                drive(pat(p, r, c), use_sof && r == 0 && c == 0, e, hin);
                if (gaps) idle($urandom_range(1, 3));
            end
        end
        idle(4);
        $display("frame %s: %0d rows, edge=%0d horiz=%0d, new errors %0d",
                 name, rows, e, h, n_err - err0);
    endtask

    initial begin
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        idle(2);

        run_frame("pass_0x123", 0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        run_frame("uniform_gx", 1, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        run_frame("colstep_gx", 2, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        run_frame("colstep_sat", 3, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        run_frame("rowstep_gy", 4, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b1);
        run_frame("rowstep_gx", 4, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b1);
        sof_only(1'b1, 1'b1);
        run_frame("rand_gy_gaps_toggle", 5, 1'b1, 1'b1, 6, 1'b1, 1'b1, 1'b0);
        run_frame("rand_gx_gaps_toggle", 5, 1'b1, 1'b0, 5, 1'b1, 1'b1, 1'b1);
        run_frame("rand_pass", 5, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1);

        // Reset mid-row with pixels in flight
        drive(pat(5, 0, 0), 1'b1, 1'b1, 1'b0);
        drive(pat(5, 0, 1), 1'b0, 1'b1, 1'b0);
        drive(pat(5, 0, 2), 1'b0, 1'b1, 1'b0);
        iRST = 1'b0;
        sb_q.delete();
        last_out = '0;
        m_row = 0;
        m_col = 0;
        m_edge = 1'b0;
        m_horiz = 1'b0;
        #1;
        check_val("rst_async_dval", oDVAL, 0);
        check_val("rst_async_out", oRed, 0);
        idle(2);
        iRST = 1'b1;
        idle(3);
        $display("mid-frame reset applied with pixels in flight");

        // No iSOF after reset: mode stays passthrough even with edge input high
        run_frame("post_rst_nosof", 5, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        run_frame("colstep_gx_again", 2, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);

        idle(6);
        check_val("drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
